// File: rtl/mos6522_timers_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mos6522_timers_pkg
//  Brief    : Shared constants and IER update helper for the 6522 timers.
//             IER write mask depends on MOS6522_T2_EN.
//  Revision : 1.0 - initial release
// ============================================================================
package mos6522_timers_pkg;

    localparam logic [15:0] c_CNT_RESET = 16'hFFFF;

`ifdef MOS6522_T2_EN
    localparam logic [6:0] c_IER_WR_MASK = 7'h7F;
`else
    localparam logic [6:0] c_IER_WR_MASK = 7'h5F;
`endif

    // Bit 7 selects set (1) or clear (0) for every enable bit given as 1.
    function automatic logic [6:0] ier_next(input logic [6:0] ier, input logic [7:0] d);
        if (d[7]) begin
            return ier | (d[6:0] & c_IER_WR_MASK);
        end
        return ier & ~d[6:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/MOS6522.vh
// Shared register offsets and bit positions for the MOS 6522 timer block.
`ifndef MOS6522_VH
`define MOS6522_VH

`define MOS6522_RS_T1CL 4'h4
`define MOS6522_RS_T1CH 4'h5
`define MOS6522_RS_T1LL 4'h6
`define MOS6522_RS_T1LH 4'h7
`define MOS6522_RS_T2CL 4'h8
`define MOS6522_RS_T2CH 4'h9
`define MOS6522_RS_ACR  4'hB
`define MOS6522_RS_IFR  4'hD
`define MOS6522_RS_IER  4'hE

`define MOS6522_IRQ_T1 6
`define MOS6522_IRQ_T2 5
`define MOS6522_ACR_T1_FREE 6

`endif

// File: rtl/mos6522_counter16.sv
`default_nettype none
// ============================================================================
//  Module   : mos6522_counter16
//  Brief    : 16-bit bus-cycle down counter with load, optional latch reload
//             at zero, and an armed bit qualifying the expiry pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module mos6522_counter16
    import mos6522_timers_pkg::*;
(
    input  logic        clk,
    input  logic        nRESET,
    input  logic        clk_en,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    input  logic        reload_en_i,
    input  logic [15:0] reload_val_i,
    output logic [15:0] count_o,
    output logic        expire_o
);

    logic [15:0] count_q, count_d;
    logic        armed_q, armed_d;
    logic        w_zero;

    assign w_zero   = (count_q == 16'h0000);
    // A load on the expiry edge wins, so the flag set is suppressed.
    assign expire_o = clk_en & ~load_i & armed_q & w_zero;
    assign count_o  = count_q;

    always_comb begin
        count_d = count_q;
        armed_d = armed_q;
        if (clk_en) begin
            if (load_i) begin
                count_d = load_val_i;
                armed_d = 1'b1;
            end else if (w_zero) begin
                if (reload_en_i) begin
                    count_d = reload_val_i;
                end else begin
                    count_d = c_CNT_RESET;
                    armed_d = 1'b0;
                end
            end else begin
                count_d = count_q - 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            count_q <= c_CNT_RESET;
            armed_q <= 1'b0;
        end else begin
            count_q <= count_d;
            armed_q <= armed_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mos6522_timers.sv
`default_nettype none
// ============================================================================
//  Module   : mos6522_timers
//  Brief    : MOS 6522 VIA timer subset: T1 (one-shot/free-run), T2
//             (one-shot), ACR, IFR, IER and nIRQ. T2 built when the macro
//             MOS6522_T2_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`include "MOS6522.vh"

module mos6522_timers
    import mos6522_timers_pkg::*;
#(
    parameter logic [15:0] T1_LATCH_INIT = 16'hFFFF
) (
    input  logic       clk,
    input  logic       nRESET,
    input  logic       clk_en,
    input  logic       nCS,
    input  logic       RnW,
    input  logic [3:0] RS,
    inout  wire  [7:0] Data_bus,
    output logic       nIRQ
);

    logic [7:0]  acr_q, acr_d;
    logic [6:0]  ier_q, ier_d;
    logic [6:0]  ifr_q, ifr_d;
    logic [7:0]  t1l_lo_q, t1l_lo_d;
    logic [7:0]  t1l_hi_q, t1l_hi_d;

    logic [7:0]  w_wdata;
    logic [7:0]  w_rdata;
    logic        w_wr, w_rd, w_irq;
    logic        w_t1_load, w_t1_expire, w_t1_clr;
    logic [15:0] w_t1_cnt;
    logic        w_t2_expire, w_t2_clr;
    logic [15:0] w_t2_cnt;

    assign w_wdata  = Data_bus;
    assign w_wr     = clk_en & ~nCS & ~RnW;
    assign w_rd     = clk_en & ~nCS & RnW;
    assign Data_bus = (!nCS && RnW) ? w_rdata : 8'hzz;

    assign w_t1_load = w_wr && (RS == `MOS6522_RS_T1CH);
    assign w_t1_clr  = w_t1_load || (w_wr && RS == `MOS6522_RS_T1LH)
                                 || (w_rd && RS == `MOS6522_RS_T1CL);

    mos6522_counter16 u_t1 (
        .clk          (clk),
        .nRESET       (nRESET),
        .clk_en       (clk_en),
        .load_i       (w_t1_load),
        .load_val_i   ({w_wdata, t1l_lo_q}),
        .reload_en_i  (acr_q[`MOS6522_ACR_T1_FREE]),
        .reload_val_i ({t1l_hi_q, t1l_lo_q}),
        .count_o      (w_t1_cnt),
        .expire_o     (w_t1_expire)
    );

`ifdef MOS6522_T2_EN
    logic [7:0] t2l_lo_q;
    logic       w_t2_load;

    assign w_t2_load = w_wr && (RS == `MOS6522_RS_T2CH);
    assign w_t2_clr  = w_t2_load || (w_rd && RS == `MOS6522_RS_T2CL);

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            t2l_lo_q <= 8'h00;
        end else if (w_wr && RS == `MOS6522_RS_T2CL) begin
            t2l_lo_q <= w_wdata;
        end
    end

    mos6522_counter16 u_t2 (
        .clk          (clk),
        .nRESET       (nRESET),
        .clk_en       (clk_en),
        .load_i       (w_t2_load),
        .load_val_i   ({w_wdata, t2l_lo_q}),
        .reload_en_i  (1'b0),
        .reload_val_i (c_CNT_RESET),
        .count_o      (w_t2_cnt),
        .expire_o     (w_t2_expire)
    );
`else
    assign w_t2_clr    = 1'b0;
    assign w_t2_expire = 1'b0;
    assign w_t2_cnt    = 16'h0000;
`endif

    assign w_irq = |(ifr_q & ier_q);
    assign nIRQ  = ~w_irq;

    always_comb begin
        acr_d    = acr_q;
        ier_d    = ier_q;
        ifr_d    = ifr_q;
        t1l_lo_d = t1l_lo_q;
        t1l_hi_d = t1l_hi_q;
        if (w_wr) begin
            case (RS)
                `MOS6522_RS_T1CL, `MOS6522_RS_T1LL: t1l_lo_d = w_wdata;
                `MOS6522_RS_T1CH, `MOS6522_RS_T1LH: t1l_hi_d = w_wdata;
                `MOS6522_RS_ACR:                    acr_d    = w_wdata;
                `MOS6522_RS_IER:                    ier_d    = ier_next(ier_q, w_wdata);
                default: ;
            endcase
        end
        // Timer sets first; any register-access clear on the same edge wins.
        if (w_t1_expire) ifr_d[`MOS6522_IRQ_T1] = 1'b1;
        if (w_t2_expire) ifr_d[`MOS6522_IRQ_T2] = 1'b1;
        if (w_wr && RS == `MOS6522_RS_IFR) ifr_d = ifr_d & ~w_wdata[6:0];
        if (w_t1_clr) ifr_d[`MOS6522_IRQ_T1] = 1'b0;
        if (w_t2_clr) ifr_d[`MOS6522_IRQ_T2] = 1'b0;
    end

    always_comb begin
        w_rdata = 8'h00;
        case (RS)
            `MOS6522_RS_T1CL: w_rdata = w_t1_cnt[7:0];
            `MOS6522_RS_T1CH: w_rdata = w_t1_cnt[15:8];
            `MOS6522_RS_T1LL: w_rdata = t1l_lo_q;
            `MOS6522_RS_T1LH: w_rdata = t1l_hi_q;
            `MOS6522_RS_T2CL: w_rdata = w_t2_cnt[7:0];
            `MOS6522_RS_T2CH: w_rdata = w_t2_cnt[15:8];
            `MOS6522_RS_ACR:  w_rdata = acr_q;
            `MOS6522_RS_IFR:  w_rdata = {w_irq, ifr_q};
            `MOS6522_RS_IER:  w_rdata = {1'b1, ier_q};
            default:          w_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            acr_q    <= 8'h00;
            ier_q    <= 7'h00;
            ifr_q    <= 7'h00;
            t1l_lo_q <= T1_LATCH_INIT[7:0];
            t1l_hi_q <= T1_LATCH_INIT[15:8];
        end else begin
            acr_q    <= acr_d;
            ier_q    <= ier_d;
            ifr_q    <= ifr_d;
            t1l_lo_q <= t1l_lo_d;
            t1l_hi_q <= t1l_hi_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mos6522_timers.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mos6522_timers
//  Brief    : Directed self-checking bench for mos6522_timers.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mos6522_timers;

    logic       clk = 1'b0;
    logic       nRESET = 1'b1;
    logic       clk_en = 1'b0;
    logic       nCS = 1'b1;
    logic       RnW = 1'b1;
    logic [3:0] RS = 4'h0;
    logic       drv_en = 1'b0;
    logic [7:0] drv_val = 8'h00;
    wire  [7:0] Data_bus;
    logic       nIRQ;
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] d;

    assign Data_bus = drv_en ? drv_val : 8'hzz;

    always #5 clk = ~clk;

    mos6522_timers #(.T1_LATCH_INIT(16'hFFFF)) dut (
        .clk      (clk),
        .nRESET   (nRESET),
        .clk_en   (clk_en),
        .nCS      (nCS),
        .RnW      (RnW),
        .RS       (RS),
        .Data_bus (Data_bus),
        .nIRQ     (nIRQ)
    );

    task automatic wr(input logic [3:0] rs, input logic [7:0] v);
        @(negedge clk);
        nCS = 1'b0; RnW = 1'b0; RS = rs; drv_val = v; drv_en = 1'b1; clk_en = 1'b1;
        @(posedge clk); #1;
        nCS = 1'b1; RnW = 1'b1; drv_en = 1'b0; clk_en = 1'b0;
    endtask

    // fx=1 performs a real bus read (side effects, one clk_en); fx=0 only peeks.
    task automatic rd(input logic [3:0] rs, input logic fx, output logic [7:0] v);
        @(negedge clk);
        nCS = 1'b0; RnW = 1'b1; RS = rs; clk_en = fx;
        #1 v = Data_bus;
        if (fx) begin
            @(posedge clk); #1;
        end
        nCS = 1'b1; clk_en = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk); clk_en = 1'b1;
            @(posedge clk); #1; clk_en = 1'b0;
        end
    endtask

    task automatic do_reset;
        @(negedge clk); nRESET = 1'b0; clk_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 nRESET = 1'b1;
    endtask

    task automatic test_reset;
        do_reset;
        rd(4'hD, 1'b0, d); n_vec++;
        if (d !== 8'h00) begin n_err++; $display("FAIL reset_ifr: got %h want 00", d); end
        rd(4'hE, 1'b0, d); n_vec++;
        if (d !== 8'h80) begin n_err++; $display("FAIL reset_ier: got %h want 80", d); end
        rd(4'hB, 1'b0, d); n_vec++;
        if (d !== 8'h00) begin n_err++; $display("FAIL reset_acr: got %h want 00", d); end
        n_vec++;
        if (nIRQ !== 1'b1) begin n_err++; $display("FAIL reset_nirq: got %b want 1", nIRQ); end
        rd(4'h6, 1'b0, d); n_vec++;
        if (d !== 8'hFF) begin n_err++; $display("FAIL reset_t1ll: got %h want ff", d); end
        rd(4'h7, 1'b0, d); n_vec++;
        if (d !== 8'hFF) begin n_err++; $display("FAIL reset_t1lh: got %h want ff", d); end
        rd(4'h5, 1'b0, d); n_vec++;
        if (d !== 8'hFF) begin n_err++; $display("FAIL reset_t1ch: got %h want ff", d); end
        rd(4'h8, 1'b0, d); n_vec++;
`ifdef MOS6522_T2_EN
        if (d !== 8'hFF) begin n_err++; $display("FAIL reset_t2cl: got %h want ff", d); end
`else
        if (d !== 8'h00) begin n_err++; $display("FAIL reset_t2cl: got %h want 00", d); end
`endif
    endtask

    task automatic test_t1_oneshot;
        wr(4'hE, 8'hC0); wr(4'hB, 8'h00); wr(4'h4, 8'h05); wr(4'h5, 8'h00);
        rd(4'h4, 1'b0, d); n_vec++;
        if (d !== 8'h05) begin n_err++; $display("FAIL os_load: got %h want 05", d); end
        tick(5);
        rd(4'hD, 1'b0, d); n_vec++;
        if (d !== 8'h00) begin n_err++; $display("FAIL os_early: got %h want 00", d); end
        tick(1);
        rd(4'hD, 1'b0, d); n_vec++;
        if (d !== 8'hC0) begin n_err++; $display("FAIL os_set: got %h want c0", d); end
        n_vec++;
        if (nIRQ !== 1'b0) begin n_err++; $display("FAIL os_nirq: got %b want 0", nIRQ); end
        rd(4'h5, 1'b0, d); n_vec++;
        if (d !== 8'hFF) begin n_err++; $display("FAIL os_wrap: got %h want ff", d); end
        wr(4'hD, 8'h20);
        rd(4'hD, 1'b0, d); n_vec++;
        if (d !== 8'hC0) begin n_err++; $display("FAIL ifr_w20: got %h want c0", d); end
        wr(4'hD, 8'h40);
        rd(4'hD, 1'b0, d); n_vec++;
        if (d !== 8'h00) begin n_err++; $display("FAIL ifr_w40: got %h want 00", d); end
        n_vec++;
        if (nIRQ !== 1'b1) begin n_err++; $display("FAIL ifr_w40_nirq: got %b want 1", nIRQ); end
        rd(4'h4, 1'b0, d); n_vec++;
        if (d !== 8'hFD) begin n_err++; $display("FAIL os_count: got %h want fd", d); end
        tick(6);
        rd(4'hD, 1'b0, d); n_vec++;
        if (d !== 8'h00) begin n_err++; $display("FAIL os_second: got %h want 00", d); end
    endtask

    task automatic test_t1_freerun;
        wr(4'hB, 8'h40); wr(4'h4, 8'h03); wr(4'h5, 8'h00);
        tick(3);
        rd(4'hD, 1'b0, d); n_vec++;
        if (d !== 8'h00) begin n_err++; $display("FAIL fr_early: got %h want 00", d); end
        tick(1);
        rd(4'hD, 1'b0, d); n_vec++;
        if (d !== 8'hC0) begin n_err++; $display("FAIL fr_set1: got %h want c0", d); end
        rd(4'h4, 1'b1, d); n_vec++;
        if (d !== 8'h03) begin n_err++; $display("FAIL fr_reload: got %h want 03", d); end
        rd(4'hD, 1'b0, d); n_vec++;
        if (d !== 8'h00) begin n_err++; $display("FAIL fr_rdclr: got %h want 00", d); end
        tick(2);
        rd(4'hD, 1'b0, d); n_vec++;
        if (d !== 8'h00) begin n_err++; $display("FAIL fr_early2: got %h want 00", d); end
        tick(1);
        rd(4'hD, 1'b0, d); n_vec++;
        if (d !== 8'hC0) begin n_err++; $display("FAIL fr_set2: got %h want c0", d); end
        rd(4'h5, 1'b1, d); n_vec++;
        if (d !== 8'h00) begin n_err++; $display("FAIL fr_t1ch: got %h want 00", d); end
        rd(4'hD, 1'b0, d); n_vec++;
        if (d !== 8'hC0) begin n_err++; $display("FAIL fr_t1ch_nofx: got %h want c0", d); end
    endtask

    task automatic test_simultaneous;
        // Counter is at 2 here; two accesses bring it to exactly 0.
        wr(4'hB, 8'h00); wr(4'hD, 8'h40);
        wr(4'h5, 8'h12);
        rd(4'hD, 1'b0, d); n_vec++;
        if (d !== 8'h00) begin n_err++; $display("FAIL sim_ifr: got %h want 00", d); end
        n_vec++;
        if (nIRQ !== 1'b1) begin n_err++; $display("FAIL sim_nirq: got %b want 1", nIRQ); end
        rd(4'h4, 1'b0, d); n_vec++;
        if (d !== 8'h03) begin n_err++; $display("FAIL sim_lo: got %h want 03", d); end
        rd(4'h5, 1'b0, d); n_vec++;
        if (d !== 8'h12) begin n_err++; $display("FAIL sim_hi: got %h want 12", d); end
        @(negedge clk);
        nCS = 1'b0; RnW = 1'b0; RS = 4'h5; drv_val = 8'hAA; drv_en = 1'b1; clk_en = 1'b0;
        repeat (4) @(posedge clk);
        #1 nCS = 1'b1; RnW = 1'b1; drv_en = 1'b0;
        rd(4'h5, 1'b0, d); n_vec++;
        if (d !== 8'h12) begin n_err++; $display("FAIL noclken_hi: got %h want 12", d); end
        rd(4'h4, 1'b0, d); n_vec++;
        if (d !== 8'h03) begin n_err++; $display("FAIL noclken_lo: got %h want 03", d); end
    endtask

    task automatic test_regs;
        rd(4'h0, 1'b0, d); n_vec++;
        if (d !== 8'h00) begin n_err++; $display("FAIL unmapped0: got %h want 00", d); end
        rd(4'hF, 1'b0, d); n_vec++;
        if (d !== 8'h00) begin n_err++; $display("FAIL unmappedF: got %h want 00", d); end
        wr(4'hE, 8'h40);
        rd(4'hE, 1'b0, d); n_vec++;
        if (d !== 8'h80) begin n_err++; $display("FAIL ier_clr: got %h want 80", d); end
        wr(4'hE, 8'hFF);
        rd(4'hE, 1'b0, d); n_vec++;
`ifdef MOS6522_T2_EN
        if (d !== 8'hFF) begin n_err++; $display("FAIL ier_set: got %h want ff", d); end
`else
        if (d !== 8'hDF) begin n_err++; $display("FAIL ier_set: got %h want df", d); end
`endif
        wr(4'hE, 8'h7F);
        rd(4'hE, 1'b0, d); n_vec++;
        if (d !== 8'h80) begin n_err++; $display("FAIL ier_clrall: got %h want 80", d); end
    endtask

    task automatic test_t2;
        wr(4'hE, 8'hA0); wr(4'h8, 8'h02); wr(4'h9, 8'h00);
        tick(2);
        rd(4'hD, 1'b0, d); n_vec++;
        if (d !== 8'h00) begin n_err++; $display("FAIL t2_early: got %h want 00", d); end
        tick(1);
        rd(4'hD, 1'b0, d); n_vec++;
`ifdef MOS6522_T2_EN
        if (d !== 8'hA0) begin n_err++; $display("FAIL t2_set: got %h want a0", d); end
        n_vec++;
        if (nIRQ !== 1'b0) begin n_err++; $display("FAIL t2_nirq: got %b want 0", nIRQ); end
        rd(4'h9, 1'b0, d); n_vec++;
        if (d !== 8'hFF) begin n_err++; $display("FAIL t2_wrap: got %h want ff", d); end
        rd(4'h8, 1'b1, d);
        rd(4'hD, 1'b0, d); n_vec++;
        if (d !== 8'h00) begin n_err++; $display("FAIL t2_rdclr: got %h want 00", d); end
`else
        if (d !== 8'h00) begin n_err++; $display("FAIL t2_set: got %h want 00", d); end
        n_vec++;
        if (nIRQ !== 1'b1) begin n_err++; $display("FAIL t2_nirq: got %b want 1", nIRQ); end
        rd(4'h9, 1'b0, d); n_vec++;
        if (d !== 8'h00) begin n_err++; $display("FAIL t2_hi: got %h want 00", d); end
        rd(4'hE, 1'b0, d); n_vec++;
        if (d !== 8'h80) begin n_err++; $display("FAIL t2_ier: got %h want 80", d); end
`endif
    endtask

    task automatic test_reset_midcount;
        wr(4'hB, 8'h40); wr(4'h4, 8'h10); wr(4'h5, 8'h00);
        tick(3);
        do_reset;
        rd(4'h4, 1'b0, d); n_vec++;
        if (d !== 8'hFF) begin n_err++; $display("FAIL rmid_lo: got %h want ff", d); end
        rd(4'h5, 1'b0, d); n_vec++;
        if (d !== 8'hFF) begin n_err++; $display("FAIL rmid_hi: got %h want ff", d); end
        rd(4'h6, 1'b0, d); n_vec++;
        if (d !== 8'hFF) begin n_err++; $display("FAIL rmid_latch: got %h want ff", d); end
        rd(4'hB, 1'b0, d); n_vec++;
        if (d !== 8'h00) begin n_err++; $display("FAIL rmid_acr: got %h want 00", d); end
        n_vec++;
        if (nIRQ !== 1'b1) begin n_err++; $display("FAIL rmid_nirq: got %b want 1", nIRQ); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_t1_oneshot;
        test_t1_freerun;
        test_simultaneous;
        test_regs;
        test_t2;
        test_reset_midcount;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
